// File: rtl/key_count_pkg.sv
// -----------------------------------------------------------------------------
// key_count_pkg
// Shared types and constants for the front-panel BCD counter controller.
//   kc_state_t    : controller FSM states
//   kc_sel_t      : which button won arbitration for the current press
//   BCD_MAX_DIGIT : largest legal value of one BCD nibble
// -----------------------------------------------------------------------------
package key_count_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        APPLY,
        REL_DB
    } kc_state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CLR,
        SEL_UP,
        SEL_DOWN
    } kc_sel_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_updown_digit.sv
// -----------------------------------------------------------------------------
// bcd_updown_digit
// Combinational single-digit BCD step, chained digit 0 first.
//   digit_i : current digit value (0..9)
//   up_i    : operation is increment
//   down_i  : operation is decrement
//   cin_i   : this digit must step (carry/borrow from the lower digit)
//   next_o  : stepped digit value
//   cout_o  : carry (up 9->0) or borrow (down 0->9) into the next digit
// -----------------------------------------------------------------------------
module bcd_updown_digit
    import key_count_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       cin_i,
    output logic [3:0] next_o,
    output logic       cout_o
);

    always_comb begin
        next_o = digit_i;
        cout_o = 1'b0;
        if (cin_i) begin
            if (up_i) begin
                // >= rather than == so a corrupted nibble still lands on 0
                if (digit_i >= BCD_MAX_DIGIT) begin
                    next_o = 4'd0;
                    cout_o = 1'b1;
                end else begin
                    next_o = digit_i + 4'd1;
                end
            end else if (down_i) begin
                if (digit_i == 4'd0) begin
                    next_o = BCD_MAX_DIGIT;
                    cout_o = 1'b1;
                end else begin
                    next_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/key_count_ctrl.sv
// -----------------------------------------------------------------------------
// key_count_ctrl
// Front-panel controller: synchronises and debounces three active-low buttons
// (up, down, clear), arbitrates them (CLR > UP > DOWN) and applies exactly one
// BCD count operation per debounced press.
//   clock      : system clock
//   reset_n    : asynchronous active-low reset
//   key_up_n   : raw up button, low = pressed, asynchronous
//   key_down_n : raw down button, low = pressed, asynchronous
//   key_clr_n  : raw clear button, low = pressed, asynchronous
//   enable     : presses accepted only while high (checked in IDLE only)
//   bcd        : DIGITS-wide BCD count, digit 0 in [3:0]
//   evt        : one-cycle pulse when bcd is updated
//   wrap       : one-cycle pulse with evt on up max->0 or down 0->max
//   busy       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module key_count_ctrl
    import key_count_pkg::*;
#(
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  key_up_n,
    input  logic                  key_down_n,
    input  logic                  key_clr_n,
    input  logic                  enable,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  evt,
    output logic                  wrap,
    output logic                  busy
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Key vectors are ordered {clr, up, down}
    logic [2:0]          sync1_q;
    logic [2:0]          sync2_q;
    kc_state_t           state_q;
    kc_sel_t             sel_q;
    logic [DB_W-1:0]     db_cnt_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic                evt_q;
    logic                wrap_q;
    logic                busy_q;

    // Two-flop synchroniser; released (high) level out of reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= {key_clr_n, key_up_n, key_down_n};
            sync2_q <= sync1_q;
        end
    end

    // Synced level of the button that owns the current sequence
    logic sel_key_n;
    always_comb begin
        case (sel_q)
            SEL_CLR:  sel_key_n = sync2_q[2];
            SEL_UP:   sel_key_n = sync2_q[1];
            SEL_DOWN: sel_key_n = sync2_q[0];
            default:  sel_key_n = 1'b1;
        endcase
    end

    // Ripple BCD step: digit 0 always steps, higher digits on carry/borrow
    logic                step_up;
    logic                step_down;
    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] bcd_stepped;

    assign step_up   = (sel_q == SEL_UP);
    assign step_down = (sel_q == SEL_DOWN);
    assign carry[0]  = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_updown_digit u_digit (
                .digit_i (bcd_q[4*gi +: 4]),
                .up_i    (step_up),
                .down_i  (step_down),
                .cin_i   (carry[gi]),
                .next_o  (bcd_stepped[4*gi +: 4]),
                .cout_o  (carry[gi+1])
            );
        end
    endgenerate

    // Controller FSM with registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sel_q    <= SEL_NONE;
            db_cnt_q <= '0;
            bcd_q    <= '0;
            evt_q    <= 1'b0;
            wrap_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            evt_q  <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && (sync2_q != 3'b111)) begin
                        if (!sync2_q[2])      sel_q <= SEL_CLR;
                        else if (!sync2_q[1]) sel_q <= SEL_UP;
                        else                  sel_q <= SEL_DOWN;
                        db_cnt_q <= '0;
                        state_q  <= PRESS_DB;
                        busy_q   <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (sel_key_n) begin
                        // Released before the debounce window closed: a bounce
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= APPLY;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                APPLY: begin
                    if (sel_q == SEL_CLR) begin
                        bcd_q  <= '0;
                        wrap_q <= 1'b0;
                    end else begin
                        bcd_q  <= bcd_stepped;
                        wrap_q <= carry[DIGITS];
                    end
                    evt_q    <= 1'b1;
                    db_cnt_q <= '0;
                    state_q  <= REL_DB;
                end
                REL_DB: begin
                    if (!sel_key_n) begin
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign evt  = evt_q;
    assign wrap = wrap_q;
    assign busy = busy_q;

endmodule
